// File: rtl/rv_defs_pkg.sv
// Shared fetch definitions: default address width, RISC-V opcodes of interest and fetch FSM encoding.
package rv_defs_pkg;

  localparam int DEF_ADDR_W = 32;

  localparam logic [31:0] RV_EBREAK = 32'h0010_0073;
  localparam logic [31:0] RV_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_counter.sv
// PC register with hold / +4 / redirect next-pc mux and redirect alignment check; pc updates one edge after the request.
// Optional MISALIGN_TRAP_EN keeps the raw target and flags it; otherwise the target is forced word aligned.
module fetch_pc_counter #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_misaligned
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_target;

`ifdef MISALIGN_TRAP_EN
  assign w_target     = i_redirect_pc;
  assign o_misaligned = |i_redirect_pc[1:0];
`else
  assign w_target     = i_redirect_pc & ~ADDR_W'(3);
  assign o_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_target;
    end else if (i_advance) begin
      r_pc <= r_pc + ADDR_W'(4);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: drives imem_addr=pc, registers {pc, instr} into a valid/ready slot 1 cycle later; halts on EBREAK.
// Backpressure: slot full and !out_ready holds pc and slot. MISALIGN_TRAP_EN enables the misaligned-redirect FAULT state.
module instr_fetch_unit
  import rv_defs_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              fetch_fault,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      r_state;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_pc;
  logic [CNT_W-1:0]  r_count;
  logic              r_halted;
  logic              r_fault;

  logic [ADDR_W-1:0] w_pc;
  logic              w_misaligned;
  logic              w_slot_free;
  logic              w_redirect;
  logic              w_load;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_redirect  = redirect_valid && (r_state == ST_RUN || r_state == ST_HALT);
  // Any redirect in RUN suppresses the load, so a flushed slot is never refilled from the stale pc.
  assign w_load      = (r_state == ST_RUN) && !redirect_valid && w_slot_free;

  fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .i_advance     (w_load),
    .i_redirect    (w_redirect),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc),
    .o_misaligned  (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_BOOT;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_count     <= '0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_instr <= imem_instr;
        r_out_pc    <= w_pc;
        r_out_valid <= 1'b1;
        r_count     <= r_count + CNT_W'(1);
      end
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN, ST_HALT: begin
          if (w_redirect) begin
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            if (w_misaligned) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end else if (w_load && imem_instr == RV_EBREAK) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (r_state == ST_HALT && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_FAULT: r_out_valid <= 1'b0;
        default:  r_state <= ST_BOOT;
      endcase
    end
  end

  assign imem_addr   = w_pc;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign halted      = r_halted;
  assign fetch_fault = r_fault;
  assign fetch_count = r_count;

endmodule
